// File: rtl/sseg_pkg.sv
// Shared types and helpers for the four-digit seven-segment scanner.
// Holds the scan state enum, display geometry and the leading-zero mask.
package sseg_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int NIB_W      = 4;
   localparam int CNT_W      = 20;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   // Bit i set means digit i is a leading zero: it and every higher digit are 0 with no dp.
   function automatic logic [NUM_DIGITS-1:0] lz_mask(
      input logic [NUM_DIGITS*NIB_W-1:0] val,
      input logic [NUM_DIGITS-1:0]       dp
   );
      logic [NUM_DIGITS-1:0] m;
      logic                  zero_run;
      m        = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS-1; i > 0; i--) begin
         zero_run = zero_run && (val[i*NIB_W +: NIB_W] == '0) && !dp[i];
         m[i]     = zero_run;
      end
      return m;
   endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// Load port of the display scanner: valid/ready transfer of four digits plus dp bits.
interface sseg_scan_mux_if;
   import sseg_pkg::*;

   logic                        load_valid;
   logic                        load_ready;
   logic [NUM_DIGITS*NIB_W-1:0] load_data;
   logic [NUM_DIGITS-1:0]       load_dp;

   modport master (
      output load_valid,
      output load_data,
      output load_dp,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  load_dp,
      output load_ready
   );

endinterface

// File: rtl/sseg_tick_gen.sv
// Slot timer: counts cycles within a digit slot and flags the end of blanking and of the slot.
module sseg_tick_gen
   import sseg_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic blank_end,
   output logic slot_end
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt <= '0;
      end else if (slot_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign slot_end  = (cnt == CNT_W'(CLK_DIV - 1));
   // With no blanking there is no BLANK state, so the strobe is never needed.
   assign blank_end = (BLANK_CYCLES != 0) && (cnt == CNT_W'(BLANK_CYCLES - 1));

endmodule

// File: rtl/sseg_scan_mux.sv
// Four-digit common-anode scanner: shadow-buffered load, per-slot blanking, registered outputs.
// Display contents change only at frame boundaries (or immediately while idle).
module sseg_scan_mux
   import sseg_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 1000,
   parameter int LZ_BLANK     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   sseg_scan_mux_if.slave        ld,
   output logic [NIB_W-1:0]      digit_nib,
   output logic [NUM_DIGITS-1:0] digit_en_n,
   output logic                  dp_n,
   output logic                  frame_done
);

   localparam logic [NUM_DIGITS-1:0] ALL_OFF = '1;

   state_t                      st, st_nxt;
   logic [1:0]                  idx, idx_nxt;
   logic [NUM_DIGITS*NIB_W-1:0] disp, disp_nxt, shadow;
   logic [NUM_DIGITS-1:0]       disp_dp, dp_nxt, shadow_dp;
   logic                        shadow_full;
   logic                        run, blank_end, slot_end, boundary, commit, accept;
   logic [NUM_DIGITS-1:0]       lz;
   logic [NIB_W-1:0]            nib_nxt;
   logic [NUM_DIGITS-1:0]       en_n_nxt;
   logic                        dpn_nxt;

   assign run      = enable && (st != IDLE);
   assign boundary = enable && (st == SHOW) && slot_end && (idx == 2'd3);
   assign commit   = shadow_full && ((st == IDLE) || boundary);
   assign accept   = ld.load_valid && !shadow_full;
   assign ld.load_ready = !shadow_full;

   sseg_tick_gen #(
      .CLK_DIV      (CLK_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_tick (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .blank_end (blank_end),
      .slot_end  (slot_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st  <= IDLE;
         idx <= '0;
      end else begin
         st  <= st_nxt;
         idx <= idx_nxt;
      end
   end

   always_comb begin
      st_nxt  = st;
      idx_nxt = idx;
      if (!enable) begin
         st_nxt  = IDLE;
         idx_nxt = '0;
      end else begin
         case (st)
            IDLE: begin
               st_nxt  = (BLANK_CYCLES == 0) ? SHOW : BLANK;
               idx_nxt = '0;
            end
            BLANK: begin
               if (blank_end) st_nxt = SHOW;
            end
            SHOW: begin
               if (slot_end) begin
                  st_nxt  = (BLANK_CYCLES == 0) ? SHOW : BLANK;
                  idx_nxt = idx + 2'd1;
               end
            end
            default: st_nxt = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state and next display so they register in step with the FSM.
   assign disp_nxt = commit ? shadow    : disp;
   assign dp_nxt   = commit ? shadow_dp : disp_dp;

   always_comb begin
      nib_nxt  = digit_nib;
      en_n_nxt = ALL_OFF;
      dpn_nxt  = 1'b1;
      lz       = (LZ_BLANK != 0) ? lz_mask(disp_nxt, dp_nxt) : '0;
      if (st_nxt == SHOW) begin
         nib_nxt = disp_nxt[{idx_nxt, 2'b00} +: NIB_W];
         if (!lz[idx_nxt]) begin
            en_n_nxt[idx_nxt] = 1'b0;
            dpn_nxt           = !dp_nxt[idx_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_nib  <= '0;
         digit_en_n <= ALL_OFF;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         digit_nib  <= nib_nxt;
         digit_en_n <= en_n_nxt;
         dp_n       <= dpn_nxt;
         frame_done <= boundary;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         disp        <= '0;
         disp_dp     <= '0;
         shadow_full <= 1'b0;
      end else if (commit) begin
         disp        <= shadow;
         disp_dp     <= shadow_dp;
         shadow_full <= 1'b0;
      end else if (accept) begin
         shadow_full <= 1'b1;
      end
   end

   // A pending value is dropped on reset by clearing the full flag alone.
   always_ff @(posedge clk) begin
      if (accept) begin
         shadow    <= ld.load_data;
         shadow_dp <= ld.load_dp;
      end
   end

endmodule
